// File: rtl/cache_pkg.sv
// Shared constants, state encoding and address helpers for the cache
// refill controller.
package cache_pkg;

  localparam int ADDR_WIDTH    = 32;
  localparam int INDEX         = 8;
  localparam int OFFSET        = 4;
  localparam int TAG           = ADDR_WIDTH - INDEX - OFFSET;
  localparam int WORD_SIZE_BIT = 32;
  localparam int BEATS         = 4;
  localparam int DATA_BLOCK    = BEATS * WORD_SIZE_BIT;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t WB   = 2'd1;
  localparam state_t RD   = 2'd2;
  localparam state_t FILL = 2'd3;

  // Field view of a byte address: tag | index | word-in-line | byte-in-word.
  typedef struct packed {
    logic [TAG-1:0]   tag;
    logic [INDEX-1:0] index;
    logic [1:0]       word;
    logic [1:0]       byte_off;
  } addr_fields_t;

  // Word-aligned address of one beat of a line.
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [TAG-1:0]   tag,
    input logic [INDEX-1:0] index,
    input logic [1:0]       beat
  );
    return {tag, index, beat, 2'b00};
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_line_buffer.sv
// Line assembly buffer: four memory words written one at a time,
// read out as one 128-bit block. Cleared whenever a new miss is accepted.
module line_buffer
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     we,
  input  logic [1:0]               windex,
  input  logic [WORD_SIZE_BIT-1:0] wdata,
  output logic [DATA_BLOCK-1:0]    block
);

  logic [BEATS-1:0][WORD_SIZE_BIT-1:0] words;

  // Word storage: clear has priority over a beat write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words <= '0;
    end else if (clear) begin
      words <= '0;
    end else if (we) begin
      words[windex] <= wdata;
    end
  end

  assign block = words;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Cache miss refill controller: optional dirty-victim write-back in four
// beats, then a four-beat line fetch, then a single-cycle fill write.
// Optional build macro CRITICAL_WORD_FIRST_EN: the fetch starts at the
// missing word and the first fetched word is forwarded on crit_valid/crit_word.
module cache_refill_ctrl
  import cache_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_req,
  input  logic [ADDR_WIDTH-1:0]    miss_addr,
  input  logic                     victim_dirty,
  input  logic [TAG-1:0]           victim_tag,
  input  logic [DATA_BLOCK-1:0]    victim_block,
  output logic                     ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDR_WIDTH-1:0]    mem_addr,
  output logic [WORD_SIZE_BIT-1:0] mem_wdata,
  input  logic                     mem_ack,
  input  logic [WORD_SIZE_BIT-1:0] mem_rdata,
  output logic                     fill_we,
  output logic [INDEX-1:0]         fill_index,
  output logic [TAG-1:0]           fill_tag,
  output logic [DATA_BLOCK-1:0]    fill_block,
  output logic                     done
`ifdef CRITICAL_WORD_FIRST_EN
  ,
  output logic                     crit_valid,
  output logic [WORD_SIZE_BIT-1:0] crit_word
`endif
);

  state_t                              state;
  logic [1:0]                          beat;
  logic [TAG-1:0]                      miss_tag_q;
  logic [TAG-1:0]                      victim_tag_q;
  logic [INDEX-1:0]                    index_q;
  logic [BEATS-1:0][WORD_SIZE_BIT-1:0] victim_words_q;
  logic [1:0]                          rd_start;
  logic [1:0]                          first_rd_beat;
  logic [DATA_BLOCK-1:0]               buf_block;
  logic                                accept;
  logic                                rd_last;
  addr_fields_t                        req_fields;
  logic                                unused_bits;

  assign req_fields = addr_fields_t'(miss_addr);
  assign accept     = (state == IDLE) && miss_req;
  // The read burst ends on the beat just before the one it started on.
  assign rd_last    = (beat + 2'd1) == rd_start;

`ifdef CRITICAL_WORD_FIRST_EN
  assign first_rd_beat = req_fields.word;
  assign unused_bits   = ^req_fields.byte_off;

  // Remember where the read burst started so its end can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_start <= 2'd0;
    end else if (accept) begin
      rd_start <= req_fields.word;
    end
  end

  // The critical word is the first read beat, which is the one at rd_start.
  always_comb begin
    crit_valid = (state == RD) && mem_ack && (beat == rd_start);
    crit_word  = crit_valid ? mem_rdata : '0;
  end
`else
  assign first_rd_beat = 2'd0;
  assign rd_start      = 2'd0;
  assign unused_bits   = ^{req_fields.word, req_fields.byte_off};
`endif

  // Miss sequencing and beat counting; mem_req is high in WB/RD so mem_ack
  // alone marks a completed beat there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      beat           <= 2'd0;
      miss_tag_q     <= '0;
      victim_tag_q   <= '0;
      index_q        <= '0;
      victim_words_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_req) begin
            miss_tag_q     <= req_fields.tag;
            index_q        <= req_fields.index;
            victim_tag_q   <= victim_tag;
            victim_words_q <= victim_block;
            if (victim_dirty) begin
              state <= WB;
              beat  <= 2'd0;
            end else begin
              state <= RD;
              beat  <= first_rd_beat;
            end
          end
        end
        WB: begin
          if (mem_ack) begin
            if (beat == 2'd3) begin
              state <= RD;
              beat  <= rd_start;
            end else begin
              beat <= beat + 2'd1;
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            beat <= beat + 2'd1;
            if (rd_last) begin
              state <= FILL;
            end
          end
        end
        default: begin
          state <= IDLE;
          beat  <= 2'd0;
        end
      endcase
    end
  end

  line_buffer u_line_buffer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept),
    .we     ((state == RD) && mem_ack),
    .windex (beat),
    .wdata  (mem_rdata),
    .block  (buf_block)
  );

  // Output decode straight from registered state so reset clears it at once.
  always_comb begin
    ready      = (state == IDLE);
    mem_req    = (state == WB) || (state == RD);
    mem_we     = (state == WB);
    mem_addr   = '0;
    mem_wdata  = '0;
    fill_we    = (state == FILL);
    done       = (state == FILL);
    fill_index = '0;
    fill_tag   = '0;
    fill_block = '0;
    case (state)
      WB: begin
        mem_addr  = beat_addr(victim_tag_q, index_q, beat);
        mem_wdata = victim_words_q[beat];
      end
      RD: begin
        mem_addr = beat_addr(miss_tag_q, index_q, beat);
      end
      FILL: begin
        fill_index = index_q;
        fill_tag   = miss_tag_q;
        fill_block = buf_block;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Directed bench for cache_refill_ctrl: reset, clean and dirty misses,
// stalled handshakes, ignored spurious inputs, mid-burst reset and
// (when built with CRITICAL_WORD_FIRST_EN) critical-word-first ordering.
`timescale 1ns/1ps
module tb_cache_refill_ctrl;
  import cache_pkg::*;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     miss_req;
  logic [ADDR_WIDTH-1:0]    miss_addr;
  logic                     victim_dirty;
  logic [TAG-1:0]           victim_tag;
  logic [DATA_BLOCK-1:0]    victim_block;
  logic                     ready;
  logic                     mem_req;
  logic                     mem_we;
  logic [ADDR_WIDTH-1:0]    mem_addr;
  logic [WORD_SIZE_BIT-1:0] mem_wdata;
  logic                     mem_ack;
  logic [WORD_SIZE_BIT-1:0] mem_rdata;
  logic                     fill_we;
  logic [INDEX-1:0]         fill_index;
  logic [TAG-1:0]           fill_tag;
  logic [DATA_BLOCK-1:0]    fill_block;
  logic                     done;
`ifdef CRITICAL_WORD_FIRST_EN
  logic                     crit_valid;
  logic [WORD_SIZE_BIT-1:0] crit_word;
`endif

  always #5 clk = ~clk;

  // Memory model: word w of any line reads as 0xA0 + w.
  assign mem_rdata = 32'hA0 + {30'd0, mem_addr[3:2]};

  cache_refill_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .miss_req     (miss_req),
    .miss_addr    (miss_addr),
    .victim_dirty (victim_dirty),
    .victim_tag   (victim_tag),
    .victim_block (victim_block),
    .ready        (ready),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .fill_we      (fill_we),
    .fill_index   (fill_index),
    .fill_tag     (fill_tag),
    .fill_block   (fill_block),
    .done         (done)
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    .crit_valid   (crit_valid),
    .crit_word    (crit_word)
`endif
  );

  localparam logic [127:0] READ_BLOCK   = 128'h000000A3_000000A2_000000A1_000000A0;
  localparam logic [127:0] VICTIM_BLOCK = 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000;

  int n_pass  = 0;
  int n_total = 0;

  logic [31:0] b_addr[$];
  logic        b_we[$];
  logic [31:0] b_wdata[$];
  int          fills;
  int          fill_cycle;
  int          stable_errs;
  int          done_errs;
  int          crit_count;
  int          crit_pos;
  logic [31:0] crit_data;
  logic [127:0] cap_block;
  logic [19:0]  cap_tag;
  logic [7:0]   cap_index;

  // Drives one miss, acts as the memory responder and records every beat.
  // abort_after >= 0 returns while the beat with that number is presented.
  task automatic run_miss(input logic [31:0] addr, input logic dirty,
                          input logic [19:0] vtag, input logic [127:0] vblock,
                          input int max_stall, input logic noise, input int abort_after);
    int          stall;
    logic        hold_valid;
    logic [31:0] hold_addr;
    logic [31:0] hold_wdata;
    b_addr.delete();
    b_we.delete();
    b_wdata.delete();
    fills = 0; fill_cycle = 0; stable_errs = 0; done_errs = 0;
    crit_count = 0; crit_pos = 0; crit_data = '0;
    cap_block = '0; cap_tag = '0; cap_index = '0;
    stall = 0;
    hold_valid = 1'b0;
    hold_addr = '0;
    hold_wdata = '0;
    @(negedge clk);
    miss_req = 1'b1; miss_addr = addr; victim_dirty = dirty;
    victim_tag = vtag; victim_block = vblock; mem_ack = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (c == 2) miss_req = 1'b0;
      if (noise && c == 3) miss_req = 1'b1;
      if (noise && c == 4) miss_req = 1'b0;
      if (abort_after >= 0 && b_addr.size() == abort_after && mem_req) begin
        mem_ack = 1'b0;
        return;
      end
      if (mem_req) begin
        if (stall > 0) begin
          mem_ack = 1'b0;
          stall--;
        end else begin
          mem_ack = 1'b1;
        end
      end else begin
        mem_ack = noise;
      end
      #1;
      if (mem_req) begin
        if (hold_valid && (mem_addr !== hold_addr || mem_wdata !== hold_wdata)) stable_errs++;
        if (mem_ack) begin
          b_addr.push_back(mem_addr);
          b_we.push_back(mem_we);
          b_wdata.push_back(mem_wdata);
          hold_valid = 1'b0;
          stall = (max_stall > 0) ? int'($urandom_range(max_stall, 0)) : 0;
        end else begin
          hold_valid = 1'b1;
          hold_addr  = mem_addr;
          hold_wdata = mem_wdata;
        end
      end
      if (fill_we === 1'b1) begin
        fills++;
        if (fill_cycle == 0) fill_cycle = c;
        cap_block = fill_block;
        cap_tag   = fill_tag;
        cap_index = fill_index;
      end
      if (fill_we !== done) done_errs++;
`ifdef CRITICAL_WORD_FIRST_EN
      if (crit_valid === 1'b1) begin
        crit_count++;
        crit_data = crit_word;
        crit_pos  = b_addr.size();
      end
`endif
      if (fill_cycle != 0 && c >= fill_cycle + 4) break;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    miss_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; miss_req = 1'b0; miss_addr = '0; victim_dirty = 1'b0;
    victim_tag = '0; victim_block = '0; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else n_pass++;
    n_total++; if (mem_req !== 1'b0 || mem_we !== 1'b0) $display("FAIL reset_mem_ctl got req=%b we=%b want 0 0", mem_req, mem_we); else n_pass++;
    n_total++; if (mem_addr !== '0 || mem_wdata !== '0) $display("FAIL reset_mem_bus got %h %h want 0 0", mem_addr, mem_wdata); else n_pass++;
    n_total++; if (fill_we !== 1'b0 || done !== 1'b0) $display("FAIL reset_fill_ctl got we=%b done=%b want 0 0", fill_we, done); else n_pass++;
    n_total++; if (fill_block !== '0 || fill_tag !== '0 || fill_index !== '0) $display("FAIL reset_fill_bus got %h %h %h want 0", fill_block, fill_tag, fill_index); else n_pass++;
    reset = 1'b0;
  endtask

  task automatic test_clean_miss;
    run_miss(32'h0001_2340, 1'b0, 20'h0, 128'h0, 0, 1'b0, -1);
    n_total++; if (b_addr.size() != 4) $display("FAIL clean_beats got %0d want 4", b_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
      n_total++;
      if (b_addr[i] !== 32'h0001_2340 + 32'(4 * i) || b_we[i] !== 1'b0)
        $display("FAIL clean_addr[%0d] got %h we=%b want %h we=0", i, b_addr[i], b_we[i], 32'h0001_2340 + 32'(4 * i));
      else n_pass++;
    end
    n_total++; if (fills != 1 || fill_cycle != 6) $display("FAIL clean_fill got fills=%0d cycle=%0d want 1 6", fills, fill_cycle); else n_pass++;
    n_total++; if (cap_block !== READ_BLOCK) $display("FAIL clean_block got %h want %h", cap_block, READ_BLOCK); else n_pass++;
    n_total++; if (cap_tag !== 20'h00012 || cap_index !== 8'h34) $display("FAIL clean_tag_index got %h %h want 00012 34", cap_tag, cap_index); else n_pass++;
    n_total++; if (done_errs != 0) $display("FAIL clean_done got %0d mismatched cycles want 0", done_errs); else n_pass++;
    n_total++; if (ready !== 1'b1) $display("FAIL clean_ready_after got %b want 1", ready); else n_pass++;
  endtask

  task automatic check_dirty_beats(input string tag_name);
    n_total++; if (b_addr.size() != 8) $display("FAIL %s_beats got %0d want 8", tag_name, b_addr.size()); else n_pass++;
    for (int i = 0; i < 8 && i < b_addr.size(); i++) begin
      logic [31:0] ea;
      logic        ew;
      logic [31:0] ed;
      if (i < 4) begin
        ea = 32'hABCD_E340 + 32'(4 * i); ew = 1'b1; ed = 32'hC0DE_0000 + 32'(i);
      end else begin
        ea = 32'h0005_6340 + 32'(4 * (i - 4)); ew = 1'b0; ed = 32'h0;
      end
      n_total++;
      if (b_addr[i] !== ea || b_we[i] !== ew || b_wdata[i] !== ed)
        $display("FAIL %s_beat[%0d] got %h/%b/%h want %h/%b/%h", tag_name, i, b_addr[i], b_we[i], b_wdata[i], ea, ew, ed);
      else n_pass++;
    end
    n_total++; if (cap_block !== READ_BLOCK) $display("FAIL %s_block got %h want %h", tag_name, cap_block, READ_BLOCK); else n_pass++;
    n_total++; if (cap_tag !== 20'h00056 || cap_index !== 8'h34) $display("FAIL %s_tag_index got %h %h want 00056 34", tag_name, cap_tag, cap_index); else n_pass++;
  endtask

  task automatic test_dirty_miss;
    run_miss(32'h0005_6340, 1'b1, 20'hABCDE, VICTIM_BLOCK, 0, 1'b0, -1);
    check_dirty_beats("dirty");
    n_total++; if (fills != 1 || fill_cycle != 10) $display("FAIL dirty_fill got fills=%0d cycle=%0d want 1 10", fills, fill_cycle); else n_pass++;
  endtask

  task automatic test_stalls;
    run_miss(32'h0005_6340, 1'b1, 20'hABCDE, VICTIM_BLOCK, 5, 1'b0, -1);
    check_dirty_beats("stall");
    n_total++; if (stable_errs != 0) $display("FAIL stall_stable got %0d changes want 0", stable_errs); else n_pass++;
    n_total++; if (fills != 1) $display("FAIL stall_fill got %0d want 1", fills); else n_pass++;
  endtask

  task automatic test_spurious;
    run_miss(32'h0001_2340, 1'b0, 20'h0, 128'h0, 0, 1'b1, -1);
    n_total++; if (b_addr.size() != 4) $display("FAIL spurious_beats got %0d want 4", b_addr.size()); else n_pass++;
    n_total++; if (fills != 1 || fill_cycle != 6) $display("FAIL spurious_fill got fills=%0d cycle=%0d want 1 6", fills, fill_cycle); else n_pass++;
    n_total++; if (cap_block !== READ_BLOCK) $display("FAIL spurious_block got %h want %h", cap_block, READ_BLOCK); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int late_fills;
    run_miss(32'h0001_2340, 1'b0, 20'h0, 128'h0, 0, 1'b0, 2);
    n_total++; if (mem_addr !== 32'h0001_2348) $display("FAIL midrst_pre_addr got %h want 00012348", mem_addr); else n_pass++;
    reset = 1'b1;
    #1;
    n_total++; if (ready !== 1'b1 || mem_req !== 1'b0 || mem_addr !== '0) $display("FAIL midrst_async got ready=%b req=%b addr=%h want 1 0 0", ready, mem_req, mem_addr); else n_pass++;
    n_total++; if (fill_we !== 1'b0 || done !== 1'b0 || fill_block !== '0) $display("FAIL midrst_fill got we=%b done=%b blk=%h want 0", fill_we, done, fill_block); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    late_fills = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      if (fill_we !== 1'b0 || mem_req !== 1'b0) late_fills++;
    end
    n_total++; if (late_fills != 0) $display("FAIL midrst_quiet got %0d active cycles want 0", late_fills); else n_pass++;
    run_miss(32'h0001_2340, 1'b0, 20'h0, 128'h0, 0, 1'b0, -1);
    n_total++; if (fills != 1 || fill_cycle != 6 || cap_block !== READ_BLOCK)
      $display("FAIL midrst_fresh got fills=%0d cycle=%0d blk=%h want 1 6 %h", fills, fill_cycle, cap_block, READ_BLOCK);
    else n_pass++;
  endtask

`ifdef CRITICAL_WORD_FIRST_EN
  task automatic test_critical_word;
    logic [31:0] exp_addr[4];
    exp_addr[0] = 32'h0001_2348; exp_addr[1] = 32'h0001_234C;
    exp_addr[2] = 32'h0001_2340; exp_addr[3] = 32'h0001_2344;
    run_miss(32'h0001_2348, 1'b0, 20'h0, 128'h0, 0, 1'b0, -1);
    n_total++; if (b_addr.size() != 4) $display("FAIL cwf_beats got %0d want 4", b_addr.size()); else n_pass++;
    for (int i = 0; i < 4 && i < b_addr.size(); i++) begin
      n_total++;
      if (b_addr[i] !== exp_addr[i]) $display("FAIL cwf_addr[%0d] got %h want %h", i, b_addr[i], exp_addr[i]);
      else n_pass++;
    end
    n_total++; if (crit_count != 1 || crit_pos != 1 || crit_data !== 32'hA2)
      $display("FAIL cwf_crit got n=%0d pos=%0d word=%h want 1 1 000000a2", crit_count, crit_pos, crit_data);
    else n_pass++;
    n_total++; if (cap_block !== READ_BLOCK) $display("FAIL cwf_block got %h want %h", cap_block, READ_BLOCK); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_stalls();
    test_spurious();
    test_reset_mid();
`ifdef CRITICAL_WORD_FIRST_EN
    test_critical_word();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-handling stage sitting directly downstream of the tag comparator (`equals`) and upstream of the data array write port that feeds the block tri-state buffer and word `mux4`.
- On a miss, optionally writes back the dirty victim line in four 32-bit beats.
- Then fetches the new line in four 32-bit beats over a req/ack memory handshake, assembles it into one 128-bit block, and issues a single-cycle fill write of data, tag and index.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- TAG, 20, tag width; equals `ADDR_WIDTH - INDEX - 4`.
- INDEX, 8, set index width.
- WORD_SIZE_BIT, 32, memory beat width.
- DATA_BLOCK, 128, line width; fixed at `4*WORD_SIZE_BIT`.

Ports:
- clk  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- miss_req  in  1  miss detected (tag compare false on a valid access); sampled only in IDLE.
- miss_addr  in  ADDR_WIDTH  address of the missing access.
- victim_dirty  in  1  victim line at `miss_addr` index is dirty.
- victim_tag  in  TAG  tag of the victim line.
- victim_block  in  DATA_BLOCK  data of the victim line.
- ready  out  1  high only in IDLE.
- mem_req  out  1  memory beat request.
- mem_we  out  1  1 = write beat, 0 = read beat.
- mem_addr  out  ADDR_WIDTH  word-aligned beat address.
- mem_wdata  out  WORD_SIZE_BIT  write-back beat data.
- mem_ack  in  1  beat completes at the rising edge where `mem_req && mem_ack`.
- mem_rdata  in  WORD_SIZE_BIT  read data, valid with `mem_ack`.
- fill_we  out  1  one-cycle write strobe to tag/data arrays.
- fill_index  out  INDEX  set being filled.
- fill_tag  out  TAG  new tag; the valid bit is set and the dirty bit cleared by the array on `fill_we`.
- fill_block  out  DATA_BLOCK  assembled line; word w at bits [32w+31:32w].
- done  out  1  one-cycle pulse, coincident with `fill_we`.

Behaviour:
- Reset: state IDLE; beat counter 0; line buffer 0; all outputs 0 except `ready`=1.
- Reset asserted mid-operation aborts the transfer immediately; no fill is issued.
- States: IDLE, WB, RD, FILL.
- IDLE:
  - On an edge with `miss_req`=1: latch `miss_addr`, `victim_tag`, `victim_block` and `victim_dirty`; clear the beat counter.
  - Go to WB if dirty, else RD.
  - `miss_req` outside IDLE is ignored; the requester must hold it until `ready` returns and the array re-evaluates.
- WB:
  - `mem_req`=1, `mem_we`=1.
  - `mem_addr = {victim_tag, index, beat, 2'b00}`; `mem_wdata` = victim word[beat].
  - Each acked edge increments beat; ack on beat 3 → RD with beat cleared.
- RD:
  - `mem_req`=1, `mem_we`=0.
  - `mem_addr = {miss_tag, index, beat, 2'b00}`.
  - Each acked edge stores `mem_rdata` into buffer word[beat] and increments beat; ack on beat 3 → FILL.
- Handshake:
  - `mem_req`, `mem_addr` and `mem_wdata` stay stable until acked.
  - Back-to-back beats are allowed: `mem_req` stays high with the next address on the cycle after an ack.
  - `mem_ack` while `mem_req`=0 is ignored.
  - Wait states of any length are allowed; there is no timeout.
- FILL:
  - `fill_we`=1 and `done`=1 for exactly one cycle.
  - `fill_index`/`fill_tag` come from the latched address; `fill_block` = buffer.
  - Next state IDLE.
  - `fill_*` buses are 0 outside FILL.
- Latency with zero-wait memory (`mem_ack` tied high):
  - clean miss: accept edge, 4 RD edges, then FILL cycle; `ready` high again 6 cycles after `miss_req` is sampled.
  - dirty miss: 10 cycles.
- Beat counter is 2 bits and wraps 3→0, which must coincide with the state change.

Optional Feature:
- Macro: CRITICAL_WORD_FIRST_EN.
- Defined:
  - RD starts at beat = `miss_addr[3:2]` and wraps modulo 4; data is still placed at buffer word[beat].
  - Extra outputs `crit_valid` (1 bit) and `crit_word` (WORD_SIZE_BIT) pulse with the first RD ack, carrying that `mem_rdata`.
  - WB order is unchanged (0..3).
- Undefined: RD always starts at beat 0; `crit_*` ports do not exist.

Decomposition:
- Package `cache_pkg`:
  - ADDR_WIDTH, TAG, INDEX, OFFSET (4), WORD_SIZE_BIT, DATA_BLOCK, BEATS (4).
  - State enum {IDLE, WB, RD, FILL}.
  - Address field slice helpers.
- One sub-module `line_buffer`: 4×32 register with indexed word write, clear on reset and on miss accept, and a 128-bit parallel read.

Test Plan:
- Clean miss, addr 0x0001_2340, ack tied high, `mem_rdata` = 0xA0..0xA3 by beat → RD addresses 0x0001_2340/44/48/4C; `fill_we` pulse on cycle 6; `fill_block` = 0x000000A3_000000A2_000000A1_000000A0; `fill_tag`=0x00012, `fill_index`=0x34.
- Dirty miss, `victim_tag`=0xABCDE, index 0x34 → WB beats to 0xABCDE340..34C with victim words 0..3 in order, then RD; `done` at cycle 10.
- Random ack stalls (0–5 wait cycles per beat) → `mem_addr`/`mem_wdata` held stable while unacked; final block identical to the zero-wait case.
- `miss_req` pulsed during RD, and `mem_ack` asserted while `mem_req`=0 → no state change, no extra beats, exactly one `fill_we`.
- Reset asserted during RD beat 2 → all outputs 0 and `ready`=1 asynchronously; no `fill_we`; a fresh miss afterward completes normally.
- With CRITICAL_WORD_FIRST_EN, `miss_addr` 0x...348 → RD order 0x348, 0x34C, 0x340, 0x344; `crit_valid` on the first ack with that word; block words are in correct positions.
